// File: rtl/ones_pkg.sv
// Shared types and helpers for the ones-count encode/decode blocks.
package ones_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} ones_exp_state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/ones_expand_sipo.sv
// Serial-in/parallel-out shift register; shifts right, serial bit enters at the MSB.
module sipo_shift_right #(
  parameter int W = 30
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         serial_in,
  output logic [W-1:0] par_out
);

  logic [W-1:0] sreg_q;
  logic [W-1:0] sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (clear)         sreg_d = '0;
    else if (shift_en) sreg_d = {serial_in, sreg_q[W-1:1]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sreg_q <= '0;
    else       sreg_q <= sreg_d;
  end

  assign par_out = sreg_q;

endmodule

// File: rtl/ones_expand.sv
// Serial thermometer generator: builds a W-bit word with the N low bits set,
// one shift per cycle, W+1 cycles from request to valid.
module ones_expand
  import ones_pkg::*;
#(
  parameter int W  = 30,
  parameter int CW = cnt_width(W)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cnt_in_ready,
  input  logic [CW-1:0] cnt_in,
  output logic          busy,
  output logic          word_out_ready,
  output logic [W-1:0]  word_out
);

  localparam logic [CW-1:0] W_C      = CW'(W);
  localparam logic [CW-1:0] LAST_C   = CW'(W - 1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  ones_exp_state_t state_q, state_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [CW-1:0]   scnt_q, scnt_d;
  logic            clear, shift_en, serial_bit;

  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    scnt_d         = scnt_q;
    clear          = 1'b0;
    shift_en       = 1'b0;
    serial_bit     = 1'b0;
    busy           = 1'b0;
    word_out_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_in_ready) begin
          rem_d   = (cnt_in > W_C) ? W_C : cnt_in;
          scnt_d  = '0;
          clear   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy       = 1'b1;
        shift_en   = 1'b1;
        serial_bit = (rem_q != '0);
        if (rem_q != '0) rem_d = rem_q - ONE_C;
        scnt_d = scnt_q + ONE_C;
        // scnt reaches W on this edge: last shift done
        if (scnt_q == LAST_C) state_d = DONE;
      end
      DONE: begin
        busy           = 1'b1;
        word_out_ready = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      scnt_q  <= scnt_d;
    end
  end

  sipo_shift_right #(.W(W)) u_sipo (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .shift_en  (shift_en),
    .serial_in (serial_bit),
    .par_out   (word_out)
  );

endmodule

// File: tb/tb_ones_expand.sv
// Directed bench for ones_expand: latency, saturation, ignored requests,
// reset behaviour, back-to-back period and a popcount round trip.
module tb_ones_expand;

  localparam int W  = 30;
  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cnt_in_ready = 1'b0;
  logic [CW-1:0] cnt_in = '0;
  logic          busy;
  logic          word_out_ready;
  logic [W-1:0]  word_out;

  int n_pass  = 0;
  int n_total = 0;

  ones_expand #(.W(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .cnt_in_ready   (cnt_in_ready),
    .cnt_in         (cnt_in),
    .busy           (busy),
    .word_out_ready (word_out_ready),
    .word_out       (word_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one request and check latency, result and return to idle.
  task automatic run(input string tag, input int n, input logic [W-1:0] exp);
    int early;
    cnt_in_ready = 1'b1;
    cnt_in       = CW'(n);
    step();
    cnt_in_ready = 1'b0;
    check({tag, " busy_after_accept"}, {31'd0, busy}, 32'd1);
    early = 0;
    for (int i = 1; i < W; i++) begin
      step();
      if (word_out_ready) early++;
    end
    check({tag, " no_early_ready"}, early, 32'd0);
    step();
    check({tag, " ready"}, {31'd0, word_out_ready}, 32'd1);
    check({tag, " word"}, {2'b00, word_out}, {2'b00, exp});
    check({tag, " popcount"}, $countones(word_out), (n > W) ? W : n);
    step();
    check({tag, " idle_ready"}, {31'd0, word_out_ready}, 32'd0);
    check({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, " word_held"}, {2'b00, word_out}, {2'b00, exp});
  endtask

  initial begin
    int pulses, first, second, cyc;
    logic [W-1:0] model;

    reset = 1'b1;
    #12;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset ready", {31'd0, word_out_ready}, 32'd0);
    check("reset word", {2'b00, word_out}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step();

    run("n5", 5, 30'h0000001F);
    run("n0", 0, 30'h00000000);
    run("n30", 30, 30'h3FFFFFFF);
    run("n31_sat", 31, 30'h3FFFFFFF);
    run("n17", 17, 30'h0001FFFF);

    // Request during an operation must be ignored.
    cnt_in_ready = 1'b1;
    cnt_in       = 5'd8;
    step();
    cnt_in_ready = 1'b0;
    pulses = 0;
    for (int i = 1; i <= W + 2; i++) begin
      if (i == 10) begin
        cnt_in_ready = 1'b1;
        cnt_in       = 5'd3;
      end
      step();
      cnt_in_ready = 1'b0;
      if (word_out_ready) pulses++;
      if (i == W) begin
        check("ign ready", {31'd0, word_out_ready}, 32'd1);
        check("ign word", {2'b00, word_out}, 32'h000000FF);
      end
    end
    check("ign pulses", pulses, 32'd1);
    check("ign idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of an operation.
    cnt_in_ready = 1'b1;
    cnt_in       = 5'd20;
    step();
    cnt_in_ready = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("mid busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid busy", {31'd0, busy}, 32'd0);
    check("mid ready", {31'd0, word_out_ready}, 32'd0);
    check("mid word", {2'b00, word_out}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    step();
    run("after_rst n1", 1, 30'h00000001);

    // Request held across reset release is accepted on the first edge.
    reset        = 1'b1;
    cnt_in_ready = 1'b1;
    cnt_in       = 5'd4;
    step();
    @(negedge clock);
    reset = 1'b0;
    step();
    check("held_rst busy", {31'd0, busy}, 32'd1);
    cnt_in_ready = 1'b0;
    cyc = 0;
    while (!word_out_ready && cyc < 100) begin
      step();
      cyc++;
    end
    check("held_rst latency", cyc, W);
    check("held_rst word", {2'b00, word_out}, 32'h0000000F);
    step();

    // Continuous request: back-to-back period.
    cnt_in_ready = 1'b1;
    cnt_in       = 5'd30;
    first  = -1;
    second = -1;
    for (int i = 0; i < 200 && second < 0; i++) begin
      step();
      if (word_out_ready) begin
        if (first < 0) first = i;
        else second = i;
      end
    end
    check("b2b found", {31'd0, (second >= 0)}, 32'd1);
    check("b2b period", second - first, W + 2);
    cnt_in_ready = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      step();
      cyc++;
    end
    check("b2b drained", {31'd0, busy}, 32'd0);

    // Round trip against a popcount for every legal N.
    for (int n = 0; n <= W; n++) begin
      model = (n == 0) ? '0 : ({W{1'b1}} >> (W - n));
      run($sformatf("rt%0d", n), n, model);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
